// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-4 demux.
// Feature macro: DEMUX_1TO4_REG_STATS_EN (per-channel transfer counters).
package demux_pkg;

  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CNT_W   = 16;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: EMPTY/FULL state, held payload, optional drain counter.
// Feature macro: DEMUX_1TO4_REG_STATS_EN enables the saturating counter.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_cnt
);

  slot_state_e       r_state;
  slot_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_load) r_data <= i_data;
    end
  end

  // A load always wins over a drain so back-to-back beats keep the slot FULL.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (i_load) w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (i_drain && !i_load) w_state_nxt = SLOT_EMPTY;
      default:    w_state_nxt = SLOT_EMPTY;
    endcase
  end

  assign o_valid = (r_state == SLOT_FULL);
  assign o_data  = r_data;

`ifdef DEMUX_1TO4_REG_STATS_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)       r_cnt <= '0;
    else if (i_drain) r_cnt <= sat_inc(r_cnt);
  end

  assign o_cnt = r_cnt;
`else
  assign o_cnt = '0;
`endif

endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer with independent one-entry slots per channel.
// Feature macro: DEMUX_1TO4_REG_STATS_EN enables xfer_cnt; otherwise it reads 0.
module demux_1to4_reg
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_data,
  input  sel_t                       in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_OUT*DATA_W-1:0]  out_data,
  output logic [NUM_OUT-1:0]         out_valid,
  input  logic [NUM_OUT-1:0]         out_ready,
  output logic [NUM_OUT*CNT_W-1:0]   xfer_cnt
);

  logic               w_accept;
  logic [NUM_OUT-1:0] w_load;
  logic [NUM_OUT-1:0] w_drain;

  // Only the addressed slot decides acceptance; other channels cannot stall it.
  always_comb begin
    in_ready = !out_valid[in_sel] || out_ready[in_sel];
    w_accept = in_valid && in_ready;
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    assign w_load[k]  = w_accept && (in_sel == SEL_W'(k));
    assign w_drain[k] = out_valid[k] && out_ready[k];

    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[k]),
      .i_drain (w_drain[k]),
      .i_data  (in_data),
      .o_valid (out_valid[k]),
      .o_data  (out_data[k*DATA_W +: DATA_W]),
      .o_cnt   (xfer_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/demux_1to4_reg.md
DEMUX_1TO4_REG -- requirements
Module: demux_1to4_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload width in bits.
REQ-002 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  meaning reset, synchronous, active-low.
REQ-004 The block SHALL have port in_data  input  DATA_W  meaning the payload to route.
REQ-005 The block SHALL have port in_sel  input  2  meaning the destination output index, 0..3.
REQ-006 The block SHALL have port in_valid  input  1  meaning in_data/in_sel are valid.
REQ-007 The block SHALL have port in_ready  output  1  meaning the block accepts the beat this cycle.
REQ-008 The block SHALL have port out_data  output  4xDATA_W  meaning the per-channel payloads; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 The block SHALL have port out_valid  output  4  meaning the per-channel valid flags.
REQ-010 The block SHALL have port out_ready  input  4  meaning the per-channel sink ready flags.
REQ-011 The block SHALL have port xfer_cnt  output  4x16  meaning the per-channel accepted-transfer counts (see Configuration).

Function
REQ-012 Each channel SHALL be a one-entry register slot with states EMPTY and FULL; out_valid[k] = (slot k == FULL).
REQ-013 A transfer in SHALL occur when in_valid && in_ready; a transfer out on channel k SHALL occur when out_valid[k] && out_ready[k].
REQ-014 in_ready SHALL be the combinational term (slot[in_sel] EMPTY) || out_ready[in_sel]; other slots SHALL NOT affect it.
REQ-015 On a transfer in, slot[in_sel] SHALL capture in_data and be FULL on the next cycle: latency exactly 1 cycle from acceptance to out_valid.
REQ-016 On a simultaneous transfer out and transfer in on the same slot, the slot SHALL stay FULL with the new data: 1 beat/cycle sustained throughput.
REQ-017 A transfer out with no transfer in on that slot SHALL change the slot FULL -> EMPTY.
REQ-018 While out_valid[k] && !out_ready[k], out_data[k] SHALL hold stable.
REQ-019 Slots SHALL operate independently; a stalled channel SHALL NOT block beats to other channels.
REQ-020 No ordering across channels SHALL be guaranteed; ordering within a channel SHALL be preserved.
REQ-021 in_ready MAY be asserted while in_valid is low; no state SHALL change without a transfer.

Reset
REQ-022 While rst_n is low at a rising edge, all slots SHALL go EMPTY, out_data SHALL be 0, and xfer_cnt SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL discard held beats without emitting them; in_ready during reset SHALL follow REQ-014 on the post-reset state from the next cycle.

Configuration
REQ-024 With macro DEMUX_1TO4_REG_STATS_EN defined, xfer_cnt[k] SHALL increment by 1 on each transfer out on channel k and saturate at 16'hFFFF.
REQ-025 Without DEMUX_1TO4_REG_STATS_EN, xfer_cnt SHALL be tied to 0, no counter flops SHALL exist, and the port list SHALL be unchanged.

Structure
REQ-026 A shared package demux_pkg SHALL hold NUM_OUT = 4, SEL_W = 2, CNT_W = 16 and typedef sel_t (logic [SEL_W-1:0]).
REQ-027 The slot SHALL be one sub-module, demux_slot (load, drain, data in, valid/data out, optional counter), instantiated four times.

Verification
REQ-028 Reset, then in_sel=2, in_data=8'hA5, in_valid=1 for one cycle with out_ready=4'hF -> out_valid=4'b0100 next cycle with out_data[2]=8'hA5, then 0.
REQ-029 out_ready=4'b0000 and send 8'h11 to ch1 -> ch1 FULL; a second beat to ch1 sees in_ready=0 and out_data[1] stays 8'h11; a beat to ch3 is accepted the same cycle.
REQ-030 Stream 8'h01..8'h08 to ch0 back-to-back with out_ready[0]=1 -> in_ready stays 1 and ch0 emits 01..08 on consecutive cycles.
REQ-031 Fill all four slots, then assert rst_n=0 for one cycle -> out_valid=0, out_data=0, no held beat is ever emitted.
REQ-032 With DEMUX_1TO4_REG_STATS_EN, 5 transfers out on ch3 -> xfer_cnt[3]=5, others 0; preloaded at 16'hFFFE, 3 more transfers -> 16'hFFFF.
REQ-033 Without DEMUX_1TO4_REG_STATS_EN, repeat REQ-032 stimulus -> xfer_cnt stays 0.
